// File: rtl/next_pc_ctrl_pkg.sv
// next_pc_ctrl_pkg: shared fetch-stage types and constants
//   INSN_PC_WIDTH / INSN_RESET_VECTOR : instruction address width and boot fetch address
//   NextPCStateType                   : next-PC controller state encoding
//   FETCH_BLOCK_BYTES                 : bytes per fetch block for the default fetch width
package next_pc_ctrl_pkg;
    localparam int INSN_PC_WIDTH = 32;
    localparam logic [31:0] INSN_RESET_VECTOR = 32'h0000_1000;
    localparam int DEFAULT_FETCH_WIDTH = 2;
    localparam int FETCH_BLOCK_BYTES = DEFAULT_FETCH_WIDTH * 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        INTR_PEND
    } NextPCStateType;

    function automatic int fetch_block_bytes(input int fetch_width);
        return fetch_width * 4;
    endfunction
endpackage

// File: rtl/FlipFlopWE.sv
// FlipFlopWE: register with write enable and asynchronous active-high clear
//   clk, rst : clock, async reset (q -> 0)
//   en, d    : load d when en
//   q        : stored value
module FlipFlopWE #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/fetch_block_incr.sv
// fetch_block_incr: address of the fetch block following the one containing pc
//   pc      : current fetch address
//   next_pc : block-aligned pc plus one block, wrapping at 2^PC_WIDTH
module fetch_block_incr
    import next_pc_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = INSN_PC_WIDTH,
    parameter int BLOCK_BYTES = FETCH_BLOCK_BYTES
) (
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] next_pc
);
    localparam logic [PC_WIDTH-1:0] BLOCK = PC_WIDTH'(BLOCK_BYTES);
    assign next_pc = (pc & ~(BLOCK - 1'b1)) + BLOCK;
endmodule

// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: selects the next fetch PC among flush, interrupt, prediction and sequential
//   stall                    : fetch cannot take a new PC
//   recoverValid/recoverPC   : pipeline flush redirect (zero latency, beats stall)
//   intrValid/intrPC         : interrupt pulse and handler address
//   predTaken/predTarget     : predicted-taken branch in current block
//   pcOut                    : current PC register value
//   pcIn/pcWE                : next PC and PC register write enable
//   fetchValid               : pcOut is a valid fetch address
//   intrAck                  : interrupt redirect written this cycle
module next_pc_ctrl
    import next_pc_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = INSN_PC_WIDTH,
    parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = INSN_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                recoverValid,
    input  logic [PC_WIDTH-1:0] recoverPC,
    input  logic                intrValid,
    input  logic [PC_WIDTH-1:0] intrPC,
    input  logic                predTaken,
    input  logic [PC_WIDTH-1:0] predTarget,
    input  logic [PC_WIDTH-1:0] pcOut,
    output logic [PC_WIDTH-1:0] pcIn,
    output logic                pcWE,
    output logic                fetchValid,
    output logic                intrAck
);
    NextPCStateType state, state_next;
    logic [PC_WIDTH-1:0] seq_pc, intr_latched;
    logic active, apply_intr;

    fetch_block_incr #(
        .PC_WIDTH(PC_WIDTH),
        .BLOCK_BYTES(fetch_block_bytes(FETCH_WIDTH))
    ) u_incr (
        .pc(pcOut),
        .next_pc(seq_pc)
    );

    // Any interrupt that cannot be applied now is remembered; a newer one overwrites it.
    FlipFlopWE #(.WIDTH(PC_WIDTH)) u_intr_latch (
        .clk(clk),
        .rst(rst),
        .en(intrValid && !apply_intr),
        .d(intrPC),
        .q(intr_latched)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else state <= state_next;
    end

    always_comb begin
        active     = state != BOOT;
        apply_intr = active && !stall && !recoverValid && (intrValid || state == INTR_PEND);
        pcWE       = active && (recoverValid || !stall);
        fetchValid = active && !recoverValid;
        intrAck    = apply_intr;
        pcIn       = !pcWE        ? seq_pc :
                     recoverValid ? recoverPC :
                     apply_intr   ? (intrValid ? intrPC : intr_latched) :
                     predTaken    ? predTarget : seq_pc;
        state_next = apply_intr ? RUN :
                     intrValid  ? INTR_PEND :
                     !active    ? RUN : state;
    end
endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb_next_pc_ctrl: directed self-checking bench for next_pc_ctrl
module tb_next_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        recoverValid = 1'b0;
    logic [31:0] recoverPC = '0;
    logic        intrValid = 1'b0;
    logic [31:0] intrPC = '0;
    logic        predTaken = 1'b0;
    logic [31:0] predTarget = '0;
    logic [31:0] pcOut = 32'h1000;
    logic [31:0] pcIn;
    logic        pcWE, fetchValid, intrAck;
    int n_checks = 0;
    int n_fail = 0;

    next_pc_ctrl #(.PC_WIDTH(32), .FETCH_WIDTH(2), .RESET_VECTOR(32'h1000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .recoverValid(recoverValid), .recoverPC(recoverPC),
        .intrValid(intrValid), .intrPC(intrPC),
        .predTaken(predTaken), .predTarget(predTarget),
        .pcOut(pcOut), .pcIn(pcIn), .pcWE(pcWE),
        .fetchValid(fetchValid), .intrAck(intrAck)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; recoverValid = 0; intrValid = 0; predTaken = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1; pcOut = 32'h1000;
        step();
        #1;
        chk("rst_pcwe", {31'b0, pcWE}, 0);
        chk("rst_fv", {31'b0, fetchValid}, 0);
        chk("rst_ack", {31'b0, intrAck}, 0);
        rst = 0;
        #1;
        chk("boot_pcwe", {31'b0, pcWE}, 0);
        chk("boot_fv", {31'b0, fetchValid}, 0);
        chk("boot_pcin", pcIn, 32'h1008);
        step();
        chk("run_pcin", pcIn, 32'h1008);
        chk("run_pcwe", {31'b0, pcWE}, 1);
        chk("run_fv", {31'b0, fetchValid}, 1);
    endtask

    task automatic test_pred();
        idle();
        pcOut = 32'h1004; predTaken = 1; predTarget = 32'h2000;
        #1;
        chk("pred_pcin", pcIn, 32'h2000);
        chk("pred_pcwe", {31'b0, pcWE}, 1);
        stall = 1;
        #1;
        chk("pred_stall_pcwe", {31'b0, pcWE}, 0);
        chk("pred_stall_pcin", pcIn, 32'h1008);
        step();
        idle();
        pcOut = 32'h1010;
        #1;
        chk("seq_pcin", pcIn, 32'h1018);
        step();
    endtask

    task automatic test_intr_stall();
        idle();
        pcOut = 32'h1018; stall = 1; intrValid = 1; intrPC = 32'h80;
        #1;
        chk("istall_pcwe", {31'b0, pcWE}, 0);
        chk("istall_ack", {31'b0, intrAck}, 0);
        step();
        intrValid = 0; intrPC = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ipend_ack", {31'b0, intrAck}, 0);
            chk("ipend_pcwe", {31'b0, pcWE}, 0);
            step();
        end
        stall = 0; predTaken = 1; predTarget = 32'h4000;
        #1;
        chk("iapply_pcin", pcIn, 32'h80);
        chk("iapply_pcwe", {31'b0, pcWE}, 1);
        chk("iapply_ack", {31'b0, intrAck}, 1);
        step();
        predTaken = 0; pcOut = 32'h80;
        #1;
        chk("iafter_ack", {31'b0, intrAck}, 0);
        chk("iafter_pcin", pcIn, 32'h88);
        step();
    endtask

    task automatic test_recover_pend();
        idle();
        pcOut = 32'h88; stall = 1; intrValid = 1; intrPC = 32'h90;
        step();
        intrValid = 0; recoverValid = 1; recoverPC = 32'h3000;
        #1;
        chk("rec_pcin", pcIn, 32'h3000);
        chk("rec_pcwe", {31'b0, pcWE}, 1);
        chk("rec_ack", {31'b0, intrAck}, 0);
        chk("rec_fv", {31'b0, fetchValid}, 0);
        step();
        recoverValid = 0; stall = 0; pcOut = 32'h3000;
        #1;
        chk("rec_intr_pcin", pcIn, 32'h90);
        chk("rec_intr_ack", {31'b0, intrAck}, 1);
        step();
    endtask

    task automatic test_overwrite();
        idle();
        pcOut = 32'h90; stall = 1; intrValid = 1; intrPC = 32'hA0;
        step();
        intrPC = 32'hB0;
        step();
        idle();
        #1;
        chk("ovw_pcin", pcIn, 32'hB0);
        chk("ovw_ack", {31'b0, intrAck}, 1);
        step();
    endtask

    task automatic test_wrap();
        idle();
        pcOut = 32'hFFFF_FFF8;
        #1;
        chk("wrap_pcin", pcIn, 32'h0);
        chk("wrap_pcwe", {31'b0, pcWE}, 1);
        pcOut = 32'hFFFF_FFFC;
        #1;
        chk("wrap_unaligned", pcIn, 32'h0);
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        pcOut = 32'h500; stall = 1; intrValid = 1; intrPC = 32'hC0;
        step();
        intrValid = 0;
        #2;
        rst = 1;
        #1;
        chk("rmid_pcwe", {31'b0, pcWE}, 0);
        chk("rmid_fv", {31'b0, fetchValid}, 0);
        chk("rmid_ack", {31'b0, intrAck}, 0);
        step();
        rst = 0; stall = 0; recoverValid = 1; recoverPC = 32'h7000;
        #1;
        chk("boot_rec_ignored", {31'b0, pcWE}, 0);
        step();
        recoverValid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rmid_no_ack", {31'b0, intrAck}, 0);
            chk("rmid_seq", pcIn, 32'h508);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_pred();
        test_intr_stall();
        test_recover_pend();
        test_overwrite();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 Parameter PC_WIDTH, 32, width of instruction addresses.
REQ-002 Parameter FETCH_WIDTH, 2, instructions fetched per cycle (4 bytes each, power of two).
REQ-003 Parameter RESET_VECTOR, 32'h0000_1000, first fetch address after reset; equals INSN_RESET_VECTOR.
REQ-004 clk  in  1  single clock, rising-edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 stall  in  1  fetch stage cannot accept a new PC this cycle.
REQ-007 recoverValid  in  1  pipeline flush, redirect to recoverPC.
REQ-008 recoverPC  in  PC_WIDTH  flush target.
REQ-009 intrValid  in  1  interrupt request, one-cycle pulse.
REQ-010 intrPC  in  PC_WIDTH  interrupt handler address.
REQ-011 predTaken  in  1  branch predictor reports taken branch in current fetch block.
REQ-012 predTarget  in  PC_WIDTH  predicted target.
REQ-013 pcOut  in  PC_WIDTH  current PC from the PC register.
REQ-014 pcIn  out  PC_WIDTH  next PC written into the PC register.
REQ-015 pcWE  out  1  PC register write enable.
REQ-016 fetchValid  out  1  pcOut is a valid fetch address this cycle.
REQ-017 intrAck  out  1  one-cycle pulse when an interrupt redirect is written.

Function
REQ-018 States: BOOT, RUN, INTR_PEND; registered state, all else combinational from state and inputs.
REQ-019 Sequential PC = (pcOut with low log2(FETCH_WIDTH*4) bits cleared) + FETCH_WIDTH*4, modulo 2^PC_WIDTH (wrap from all-ones block to 0, no flag).
REQ-020 BOOT: pcWE=0, fetchValid=0, intrAck=0; next state RUN unconditionally, except an intrValid in BOOT goes to INTR_PEND and recoverValid is ignored.
REQ-021 RUN/INTR_PEND priority when pcWE: recoverValid > interrupt (pending or new) > predTaken > sequential.
REQ-022 recoverValid in RUN or INTR_PEND: pcIn=recoverPC, pcWE=1 regardless of stall, same cycle (zero latency).
REQ-023 Interrupt applied only when stall=0 and recoverValid=0: pcIn=intrPC (new) or latched address (pending), pcWE=1, intrAck=1, next state RUN.
REQ-024 intrValid not applied this cycle (stall=1, recoverValid=1, or BOOT): latch intrPC, next state INTR_PEND.
REQ-025 intrValid while already INTR_PEND: new intrPC overwrites latched address; state unchanged unless applied.
REQ-026 RUN, stall=0, no recover/interrupt: pcWE=1, pcIn=predTarget if predTaken else sequential PC.
REQ-027 stall=1 with no recoverValid: pcWE=0, predTaken ignored (predictor re-presents).
REQ-028 fetchValid=1 in RUN and INTR_PEND, 0 in BOOT and in any cycle where recoverValid=1.
REQ-029 pcIn shall equal sequential PC whenever pcWE=0 (deterministic, no X).
REQ-030 intrAck never asserted in a cycle with recoverValid=1.

Reset
REQ-031 Asserting rst forces state=BOOT and latched interrupt address=0 immediately, asynchronously; outputs take BOOT values (pcWE=0, fetchValid=0, intrAck=0).
REQ-032 Reset mid-operation discards any pending interrupt; PC register reload to RESET_VECTOR is owned by the PC register, not this block.

Structure
REQ-033 State enum NextPCStateType and FETCH_BLOCK_BYTES constant belong in the shared fetch-stage package; PC_WIDTH and INSN_RESET_VECTOR from existing shared packages.
REQ-034 Interrupt latch shall use the codebase FlipFlopWE primitive; sequential-PC adder is a natural sub-module: fetch_block_incr.

Verification
REQ-035 Reset release, pcOut=32'h1000, FETCH_WIDTH=2 -> cycle0 pcWE=0 fetchValid=0; cycle1 pcIn=32'h1008 pcWE=1 fetchValid=1.
REQ-036 pcOut=32'h1004, predTaken=1 predTarget=32'h2000 -> pcIn=32'h2000; same with stall=1 -> pcWE=0.
REQ-037 stall=1, intrValid pulse intrPC=32'h80 -> INTR_PEND, pcWE=0; stall drops 3 cycles later -> pcIn=32'h80 pcWE=1 intrAck=1 once.
REQ-038 INTR_PEND with recoverValid=1 recoverPC=32'h3000, stall=1 -> pcIn=32'h3000 pcWE=1 intrAck=0 fetchValid=0; next unstalled cycle applies interrupt.
REQ-039 pcOut=32'hFFFF_FFF8, no redirect -> pcIn=32'h0 pcWE=1.
REQ-040 rst asserted mid-cycle while INTR_PEND -> outputs immediately BOOT values; after release no intrAck ever issued for the dropped interrupt.
